// File: rtl/crc32_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_arb_ctrl
//  Function : Two-requester round-robin arbiter feeding a 32-bit-per-cycle
//             MSB-first CRC-32 engine. One frame is owned end to end by the
//             granted requester, and its result is held until consumed.
//  Options  : CRC32_FINAL_XOR_EN - when defined, the result is inverted
//             (XOR 32'hFFFFFFFF) before presentation; latency is unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module crc32_arb_ctrl #(
    parameter logic [31:0] CRC_POLY = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_id,
    input  logic        res_ready,
    output logic        busy
);

`ifdef CRC32_FINAL_XOR_EN
    localparam logic [31:0] c_final_xor = 32'hFFFFFFFF;
`else
    localparam logic [31:0] c_final_xor = 32'h00000000;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_grant;
    logic        r_ptr;
    logic [31:0] r_crc;
    logic        r_ready0;
    logic        r_ready1;
    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic        r_res_id;

    logic        w_pick;
    logic        w_sel_valid;
    logic [31:0] w_sel_data;
    logic        w_sel_last;
    logic [31:0] w_next_crc;

    // Thirty-two serial MSB-first LFSR steps folded into one cycle.
    function automatic logic [31:0] crc_word(input logic [31:0] crc_in,
                                             input logic [31:0] din);
        logic [31:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((din[i] ^ c[31]) ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

    // Arbitration pick and granted-requester data mux.
    always_comb begin
        w_pick      = (req0_valid & req1_valid) ? r_ptr : req1_valid;
        w_sel_valid = r_grant ? req1_valid : req0_valid;
        w_sel_data  = r_grant ? req1_data  : req0_data;
        w_sel_last  = r_grant ? req1_last  : req0_last;
        w_next_crc  = crc_word(r_crc, w_sel_data);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_ptr       <= 1'b0;
            r_crc       <= CRC_INIT;
            r_ready0    <= 1'b0;
            r_ready1    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'h0000_0000;
            r_res_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_valid | req1_valid) begin
                        r_grant <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // Readies are raised here so they appear exactly in RUN.
                    r_crc    <= CRC_INIT;
                    r_ready0 <= ~r_grant;
                    r_ready1 <= r_grant;
                    r_state  <= RUN;
                end
                RUN: begin
                    // A low valid from the owner simply stalls; no pre-emption.
                    if (w_sel_valid) begin
                        r_crc <= w_next_crc;
                        if (w_sel_last) begin
                            r_ready0    <= 1'b0;
                            r_ready1    <= 1'b0;
                            r_res_valid <= 1'b1;
                            r_res_data  <= w_next_crc ^ c_final_xor;
                            r_res_id    <= r_grant;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result held until consumed; then favour the other side.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= ~r_grant;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = r_ready0;
    assign req1_ready = r_ready1;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_id     = r_res_id;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crc32_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc32_arb_ctrl
//  Function : Self-checking bench for crc32_arb_ctrl. A frame-level reference
//             (polynomial long division) and a protocol model are compared
//             against the DUT every cycle, after directed and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc32_arb_ctrl;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] INIT = 32'h00000000;
`ifdef CRC32_FINAL_XOR_EN
    localparam logic [31:0] FX    = 32'hFFFFFFFF;
    localparam logic [31:0] EXP20 = 32'hFB3EE248;
`else
    localparam logic [31:0] FX    = 32'h00000000;
    localparam logic [31:0] EXP20 = 32'h04C11DB7;
`endif
    localparam logic [31:0] EXP21 = 32'h09823B6E ^ FX;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  v = 2'b00;
    logic [31:0] d [2];
    logic [1:0]  l = 2'b00;
    logic        res_ready = 1'b0;

    logic        dut_rdy0, dut_rdy1, dut_rvalid, dut_rid, dut_busy;
    logic [31:0] dut_rdata;

    crc32_arb_ctrl #(.CRC_POLY(POLY), .CRC_INIT(INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v[0]),
        .req0_data  (d[0]),
        .req0_last  (l[0]),
        .req0_ready (dut_rdy0),
        .req1_valid (v[1]),
        .req1_data  (d[1]),
        .req1_last  (l[1]),
        .req1_ready (dut_rdy1),
        .res_valid  (dut_rvalid),
        .res_data   (dut_rdata),
        .res_id     (dut_rid),
        .res_ready  (res_ready),
        .busy       (dut_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int n_results = 0;

    // Outputs seen at the previous sample point (state before the last edge)
    logic [1:0]  p_rdy = 2'b00;
    logic        p_rvalid = 1'b0;
    logic        p_rid = 1'b0;
    logic [31:0] p_rdata = 32'h0;
    logic [1:0]  acc = 2'b00;

    // Expected frame results per requester, in completion order
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];

    // Protocol model: 0 idle, 1 granted, 2 running, 3 result pending
    int          m_phase = 0;
    logic        m_owner = 1'b0;
    logic        m_ptr = 1'b0;
    logic        m_rvalid = 1'b0;
    logic        m_rid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_words[$];

    // Random-traffic frame generators
    logic [31:0] fw [2][4];
    int          flen [2];
    int          fidx [2];
    logic [1:0]  fact = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // CRC as remainder of (message with init folded into the first 32 bits) * x^32 mod P
    function automatic logic [31:0] ref_crc(input logic [31:0] w[$]);
        bit          bits[$];
        logic [31:0] ini, pol, wd, r;
        int          n;
        ini = INIT;
        pol = POLY;
        foreach (w[k]) begin
            wd = w[k];
            for (int i = 31; i >= 0; i--) bits.push_back(wd[i]);
        end
        for (int i = 0; i < 32; i++) bits[i] = bits[i] ^ ini[31-i];
        for (int i = 0; i < 32; i++) bits.push_back(1'b0);
        n = bits.size();
        for (int i = 0; i + 32 < n; i++) begin
            if (bits[i]) begin
                bits[i] = 1'b0;
                for (int j = 1; j <= 32; j++) bits[i+j] = bits[i+j] ^ pol[32-j];
            end
        end
        r = 32'h0;
        for (int j = 0; j < 32; j++) r[31-j] = bits[n-32+j];
        return r;
    endfunction

    function automatic logic [31:0] crc1(input logic [31:0] w0);
        logic [31:0] q[$];
        q.push_back(w0);
        return ref_crc(q);
    endfunction

    // Advance the protocol model over one clock edge using the inputs driven before it
    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_ptr = 1'b0; m_owner = 1'b0;
            m_rvalid = 1'b0; m_rdata = 32'h0; m_rid = 1'b0;
            m_words.delete();
        end else begin
            case (m_phase)
                0: if (v[0] || v[1]) begin
                       m_owner = (v[0] && v[1]) ? m_ptr : v[1];
                       m_phase = 1;
                   end
                1: begin m_words.delete(); m_phase = 2; end
                2: if (v[m_owner]) begin
                       m_words.push_back(d[m_owner]);
                       if (l[m_owner]) begin
                           m_rvalid = 1'b1;
                           m_rdata  = ref_crc(m_words) ^ FX;
                           m_rid    = m_owner;
                           m_phase  = 3;
                       end
                   end
                default: if (res_ready) begin
                       m_rvalid = 1'b0;
                       m_ptr    = ~m_owner;
                       m_phase  = 0;
                   end
            endcase
        end
    endtask

    // One clock: sample at negedge, score the handshake, step model, compare
    task automatic cycle();
        @(negedge clk);
        acc[0] = !rst && v[0] && p_rdy[0];
        acc[1] = !rst && v[1] && p_rdy[1];
        if (!rst && p_rvalid && res_ready) begin
            n_results++;
            if (p_rid == 1'b0 && sb0.size() > 0) chk("sb_crc0", p_rdata, sb0.pop_front());
            else if (p_rid == 1'b1 && sb1.size() > 0) chk("sb_crc1", p_rdata, sb1.pop_front());
            else begin
                checks++;
                $display("FAIL sb_unexpected: result for requester %0d with nothing expected", p_rid);
            end
        end
        model_step();
        chk("ready0", dut_rdy0, (m_phase == 2 && m_owner == 1'b0));
        chk("ready1", dut_rdy1, (m_phase == 2 && m_owner == 1'b1));
        chk("busy", dut_busy, (m_phase != 0));
        chk("res_valid", dut_rvalid, m_rvalid);
        if (m_rvalid) begin
            chk("res_data", dut_rdata, m_rdata);
            chk("res_id", dut_rid, m_rid);
        end
        p_rdy = {dut_rdy1, dut_rdy0};
        p_rvalid = dut_rvalid;
        p_rid = dut_rid;
        p_rdata = dut_rdata;
    endtask

    task automatic wait_accept(input int n);
        bit got;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            if (acc[n]) got = 1;
        end
        if (!got) begin
            checks++;
            $display("FAIL accept_timeout: requester %0d word not taken within 40 cycles", n);
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; v = 2'b00; l = 2'b00; res_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        sb0.delete();
        sb1.delete();
    endtask

    // Random requester behaviour; frames are pushed to the scoreboard when created
    task automatic drive_random();
        if (rst) begin
            fact = 2'b00;
            sb0.delete();
            sb1.delete();
        end
        for (int n = 0; n < 2; n++) begin
            if (acc[n] && fact[n]) begin
                fidx[n]++;
                if (fidx[n] == flen[n]) fact[n] = 1'b0;
            end
            if (!fact[n] && $urandom_range(0, 3) == 0) begin
                logic [31:0] q[$];
                flen[n] = $urandom_range(1, 4);
                for (int k = 0; k < flen[n]; k++) begin
                    fw[n][k] = $urandom;
                    q.push_back(fw[n][k]);
                end
                if (n == 0) sb0.push_back(ref_crc(q) ^ FX);
                else        sb1.push_back(ref_crc(q) ^ FX);
                fidx[n] = 0;
                fact[n] = 1'b1;
            end
            if (fact[n] && $urandom_range(0, 3) != 0) begin
                v[n] = 1'b1;
                d[n] = fw[n][fidx[n]];
                l[n] = (fidx[n] == flen[n] - 1);
            end else begin
                v[n] = 1'b0;
                d[n] = $urandom;
                l[n] = 1'($urandom_range(0, 1));
            end
        end
        res_ready = ($urandom_range(0, 4) != 0);
        rst = ($urandom_range(0, 399) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, e;
        d[0] = 32'h0; d[1] = 32'h0;

        // Pin the reference itself with hand-computed values
        chk("ref_single", crc1(32'h00000001) ^ FX, EXP20);
        begin
            logic [31:0] q[$];
            q.push_back(32'h0); q.push_back(32'h2);
            chk("ref_two", ref_crc(q) ^ FX, EXP21);
        end

        // Reset state
        do_reset();
        chk("rst_res_valid", dut_rvalid, 0);
        chk("rst_res_data", dut_rdata, 0);
        chk("rst_res_id", dut_rid, 0);
        chk("rst_busy", dut_busy, 0);
        chk("rst_ready0", dut_rdy0, 0);
        chk("rst_ready1", dut_rdy1, 0);

        // Single-word frame from requester 0
        sb0.push_back(EXP20);
        v[0] = 1; d[0] = 32'h1; l[0] = 1;
        wait_accept(0);
        v[0] = 0;
        chk("single_valid_next", dut_rvalid, 1);
        chk("single_data", dut_rdata, EXP20);
        chk("single_id", dut_rid, 0);
        handshake();

        // Two-word frame from requester 1 with a 3-cycle gap; requester 0 waits
        sb1.push_back(EXP21);
        v[1] = 1; d[1] = 32'h0; l[1] = 0;
        wait_accept(1);
        v[1] = 0;
        sb0.push_back(EXP20);
        v[0] = 1; d[0] = 32'h1; l[0] = 1;
        for (int k = 0; k < 3; k++) begin
            d[1] = $urandom;
            cycle();
            chk("gap_ready1", dut_rdy1, 1);
            chk("gap_ready0", dut_rdy0, 0);
        end
        v[1] = 1; d[1] = 32'h2; l[1] = 1;
        wait_accept(1);
        v[1] = 0;
        chk("two_data", dut_rdata, EXP21);
        chk("two_id", dut_rid, 1);
        handshake();
        wait_accept(0);
        v[0] = 0;
        handshake();

        // Simultaneous requests right after reset: 0 first, then 1
        do_reset();
        a = 32'hDEADBEEF; b = 32'h12345678;
        sb0.push_back(crc1(a) ^ FX);
        sb1.push_back(crc1(b) ^ FX);
        v = 2'b11; d[0] = a; d[1] = b; l = 2'b11;
        wait_accept(0);
        v[0] = 0;
        chk("simul_first_id", dut_rid, 0);
        handshake();
        wait_accept(1);
        v[1] = 0;
        chk("simul_second_id", dut_rid, 1);
        handshake();

        // Result backpressure for 5 cycles with requester 1 waiting
        a = 32'hA5A5_0F0F; b = 32'h0000_FFFF;
        sb0.push_back(crc1(a) ^ FX);
        v[0] = 1; d[0] = a; l[0] = 1;
        wait_accept(0);
        v[0] = 0;
        sb1.push_back(crc1(b) ^ FX);
        v[1] = 1; d[1] = b; l[1] = 1;
        res_ready = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_valid", dut_rvalid, 1);
            chk("bp_data", dut_rdata, crc1(a) ^ FX);
            chk("bp_id", dut_rid, 0);
            chk("bp_ready1", dut_rdy1, 0);
        end
        handshake();
        wait_accept(1);
        v[1] = 0;
        handshake();

        // Reset mid-frame with pointer at 1: frame abandoned, pointer back to 0
        sb0.push_back(EXP20);
        v[0] = 1; d[0] = 32'h1; l[0] = 1;
        wait_accept(0);
        v[0] = 0;
        handshake();
        v[0] = 1; d[0] = 32'h0BAD_F00D; l[0] = 0;
        wait_accept(0);
        v[0] = 0;
        rst = 1;
        cycle();
        rst = 0;
        sb0.delete(); sb1.delete();
        chk("midrst_valid", dut_rvalid, 0);
        chk("midrst_busy", dut_busy, 0);
        cycle();
        chk("midrst_valid2", dut_rvalid, 0);
        e = 32'h7777_0001;
        sb0.push_back(EXP20);
        sb1.push_back(crc1(e) ^ FX);
        v = 2'b11; d[0] = 32'h1; d[1] = e; l = 2'b11;
        wait_accept(0);
        v[0] = 0;
        chk("post_rst_id", dut_rid, 0);
        chk("post_rst_data", dut_rdata, EXP20);
        handshake();
        wait_accept(1);
        v[1] = 0;
        handshake();

        // Randomised traffic with occasional resets
        do_reset();
        n_results = 0;
        for (int k = 0; k < 4000; k++) begin
            drive_random();
            cycle();
        end
        chk("random_results_seen", (n_results > 20), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
